des_round_ctrl: RTL and testbench
=================================

DES_ROUND_CTRL -- requirements
Module: des_round_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have: start  in  1  request a new block; qualified by in_ready.
REQ-003 SHALL have: in_ready  out  1  controller can accept start.
REQ-004 SHALL have: decrypt  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
REQ-005 SHALL have: key  in  64  DES key incl. parity, FIPS 46-3 bit 1 = MSB; sampled on accept.
REQ-006 SHALL have: load_init  out  1  L/R data registers capture IP(plaintext) this cycle.
REQ-007 SHALL have: en  out  1  L/R data registers step one Feistel round this cycle.
REQ-008 SHALL have: round  out  5  current round 1..16 while en=1, else 0.
REQ-009 SHALL have: subkey  out  48  round key for the current round, valid whenever en=1.
REQ-010 SHALL have: out_valid  out  1  R16/L16 final in data registers; in_ready  out_ready  in  1  downstream accepts.

Function
REQ-011 SHALL implement FSM IDLE -> LOAD -> ROUND -> DONE -> IDLE.
REQ-012 IDLE: in_ready=1, all other outputs 0; start=1 is the accept at that clock edge -> LOAD.
REQ-013 LOAD: exactly one cycle; load_init=1, en=0; next state ROUND with round=1.
REQ-014 ROUND: 16 cycles; en=1, round=1..16 incrementing each edge; after round 16 -> DONE.
REQ-015 DONE: out_valid=1, en=0, load_init=0; hold until out_ready=1, then -> IDLE on that edge.
REQ-016 in_ready SHALL be 1 only in IDLE; start outside IDLE SHALL be ignored (no queuing).
REQ-017 Latency: out_valid rises 17 cycles after the accept edge (1 LOAD + 16 ROUND).
REQ-018 key and decrypt SHALL be captured at accept; later input changes SHALL not affect the block in flight.
REQ-019 Key state: 28-bit C and D registers; subkey = PC-2(C,D), combinational from the registers.
REQ-020 Shift schedule per FIPS 46-3: rounds 1, 2, 9, 16 shift 1; all others shift 2; total 28.
REQ-021 Encrypt accept: C,D <= rotl1(PC-1(key)) so round 1 sees K1; after round r<16, rotate left by shift[r+1].
REQ-022 Decrypt accept: C,D <= PC-1(key) (= C16,D16) so round 1 sees K16; after round r, rotate right by shift[17-r].
REQ-023 C,D SHALL hold in IDLE, LOAD and DONE; rotation only on en=1 edges.
REQ-024 load_init and en SHALL never be 1 in the same cycle.
REQ-025 out_ready=1 outside DONE SHALL have no effect.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, C=D=0, round=0, load_init=en=out_valid=0, in_ready=1 after release.
REQ-027 Reset mid-LOAD/ROUND/DONE SHALL abandon the block; no out_valid for it.
REQ-028 First accept after reset release SHALL behave identically to any other accept.

Structure
REQ-029 Package des_pkg SHALL hold: PC-1 and PC-2 tables, shift schedule (16 entries), NUM_ROUNDS=16, FSM state encoding.
REQ-030 Key schedule (C/D registers, PC-1 load, left/right rotate, PC-2) SHALL be sub-module des_key_sched; FSM and round counter stay in des_round_ctrl.

Verification
REQ-031 Encrypt, key=133457799BBCDFF1, start in IDLE -> load_init one cycle, then round 1 subkey=1B02EFFC7072, round 16 subkey=CB3D8B0E17F5, out_valid 17 cycles after accept.
REQ-032 Decrypt, same key -> round 1 subkey=CB3D8B0E17F5, round 16 subkey=1B02EFFC7072; all 16 subkeys are the encrypt sequence reversed.
REQ-033 Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, en=0, in_ready=0; out_ready=1 -> IDLE next edge; start asserted in DONE is ignored.
REQ-034 Change key/decrypt during ROUND -> subkeys unchanged; start pulsed during ROUND -> no restart, round count unbroken.
REQ-035 Assert rst=0 at round 7 -> outputs zero immediately, in_ready=1 after release; next encrypt reproduces REQ-031 exactly.
REQ-036 Back-to-back: out_ready tied 1, start tied 1 -> one accept every 19 cycles, load_init and en never both 1.

Source files
------------

// File: rtl/des_pkg.sv
// Shared constants, permutation tables and helpers for the DES round controller.
package des_pkg;

   localparam int unsigned NUM_ROUNDS = 16;
   localparam int unsigned KEY_W      = 64;
   localparam int unsigned CD_W       = 56;
   localparam int unsigned HALF_W     = 28;
   localparam int unsigned SUBKEY_W   = 48;
   localparam int unsigned ROUND_W    = 5;
   localparam int unsigned STATE_W    = 2;

   // FSM state encoding
   localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [STATE_W-1:0] ST_LOAD  = 2'd1;
   localparam logic [STATE_W-1:0] ST_ROUND = 2'd2;
   localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

   // PC-1: entry i names the key bit (1 = MSB) landing in CD bit i (0 = MSB)
   localparam int unsigned PC1_TAB [CD_W] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   // PC-2: entry i names the CD bit (1 = MSB) landing in subkey bit i (0 = MSB)
   localparam int unsigned PC2_TAB [SUBKEY_W] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // Left-shift amount for rounds 1..16 (index 0 = round 1)
   localparam logic [1:0] SHIFT_TAB [NUM_ROUNDS] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   // Permuted choice 1 from the 64-bit key to {C,D}
   function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
      logic [CD_W-1:0] o;
      o = '0;
      for (int i = 0; i < int'(CD_W); i++)
         o[6'(int'(CD_W) - 1 - i)] = k[6'(int'(KEY_W) - int'(PC1_TAB[i]))];
      return o;
   endfunction

   // Permuted choice 2 from {C,D} to the 48-bit round key
   function automatic logic [SUBKEY_W-1:0] pc2(input logic [CD_W-1:0] cd);
      logic [SUBKEY_W-1:0] o;
      o = '0;
      for (int i = 0; i < int'(SUBKEY_W); i++)
         o[6'(int'(SUBKEY_W) - 1 - i)] = cd[6'(int'(CD_W) - int'(PC2_TAB[i]))];
      return o;
   endfunction

   // Rotate a 28-bit half left by 0, 1 or 2
   function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input logic [1:0] n);
      case (n)
         2'd1:    return {x[HALF_W-2:0], x[HALF_W-1]};
         2'd2:    return {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
         default: return x;
      endcase
   endfunction

   // Rotate a 28-bit half right by 0, 1 or 2
   function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input logic [1:0] n);
      case (n)
         2'd1:    return {x[0], x[HALF_W-1:1]};
         2'd2:    return {x[1:0], x[HALF_W-1:2]};
         default: return x;
      endcase
   endfunction

endpackage

// File: rtl/des_round_ctrl_if.sv
// Request/round-control/result bundle between a DES datapath owner and the controller.
interface des_round_ctrl_if;
   logic                            start;
   logic                            in_ready;
   logic                            decrypt;
   logic [des_pkg::KEY_W-1:0]       key;
   logic                            load_init;
   logic                            en;
   logic [des_pkg::ROUND_W-1:0]     round;
   logic [des_pkg::SUBKEY_W-1:0]    subkey;
   logic                            out_valid;
   logic                            out_ready;

   modport master (
      output start, decrypt, key, out_ready,
      input  in_ready, load_init, en, round, subkey, out_valid
   );

   modport slave (
      input  start, decrypt, key, out_ready,
      output in_ready, load_init, en, round, subkey, out_valid
   );
endinterface

// File: rtl/des_key_sched.sv
// DES key schedule: C/D halves loaded through PC-1, rotated per round, PC-2 to subkey.
module des_key_sched
   import des_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                decrypt,
   input  logic [KEY_W-1:0]    key,
   input  logic                step,
   input  logic [ROUND_W-1:0]  round,
   output logic [SUBKEY_W-1:0] subkey
);

   logic [HALF_W-1:0] c_q;
   logic [HALF_W-1:0] d_q;
   logic              dec_q;
   logic [CD_W-1:0]   cd_pc1;
   logic [1:0]        amt;
   logic              last_round;

   assign cd_pc1     = pc1(key);
   assign last_round = (round == ROUND_W'(NUM_ROUNDS));

   // Rotation applied at the end of the current round: forward schedule for encrypt, reversed for decrypt
   always_comb begin
      amt = 2'd0;
      if (dec_q)
         amt = SHIFT_TAB[4'(ROUND_W'(NUM_ROUNDS) - round)];
      else if (!last_round)
         amt = SHIFT_TAB[round[3:0]];
   end

   // C/D state: K1 or K16 position at accept, then one rotation per active round
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c_q   <= '0;
         d_q   <= '0;
         dec_q <= 1'b0;
      end else if (load) begin
         dec_q <= decrypt;
         if (decrypt) begin
            c_q <= cd_pc1[CD_W-1:HALF_W];
            d_q <= cd_pc1[HALF_W-1:0];
         end else begin
            c_q <= rotl28(cd_pc1[CD_W-1:HALF_W], 2'd1);
            d_q <= rotl28(cd_pc1[HALF_W-1:0], 2'd1);
         end
      end else if (step) begin
         if (dec_q) begin
            c_q <= rotr28(c_q, amt);
            d_q <= rotr28(d_q, amt);
         end else begin
            c_q <= rotl28(c_q, amt);
            d_q <= rotl28(d_q, amt);
         end
      end
   end

   assign subkey = pc2({c_q, d_q});

endmodule

// File: rtl/des_round_ctrl.sv
// DES round sequencer: accept, load IP, 16 Feistel rounds with subkeys, hold result until taken.
module des_round_ctrl
   import des_pkg::*;
(
   input logic             clk,
   input logic             rst,
   des_round_ctrl_if.slave bus
);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_nxt;
   logic [ROUND_W-1:0] round_q;
   logic [ROUND_W-1:0] round_nxt;
   logic               in_ready_q;
   logic               in_ready_nxt;
   logic               load_init_q;
   logic               load_init_nxt;
   logic               en_q;
   logic               en_nxt;
   logic               out_valid_q;
   logic               out_valid_nxt;
   logic               accept;
   logic [SUBKEY_W-1:0] subkey;

   assign accept = (state_q == ST_IDLE) && bus.start;

   // Next state and next registered outputs, decoded from the state being entered
   always_comb begin
      state_nxt     = state_q;
      round_nxt     = '0;
      in_ready_nxt  = 1'b0;
      load_init_nxt = 1'b0;
      en_nxt        = 1'b0;
      out_valid_nxt = 1'b0;

      case (state_q)
         ST_IDLE:  if (bus.start) state_nxt = ST_LOAD;
         ST_LOAD:  state_nxt = ST_ROUND;
         ST_ROUND: if (round_q == ROUND_W'(NUM_ROUNDS)) state_nxt = ST_DONE;
         ST_DONE:  if (bus.out_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase

      case (state_nxt)
         ST_IDLE:  in_ready_nxt  = 1'b1;
         ST_LOAD:  load_init_nxt = 1'b1;
         ST_ROUND: begin
            en_nxt    = 1'b1;
            round_nxt = (state_q == ST_ROUND) ? round_q + ROUND_W'(1) : ROUND_W'(1);
         end
         ST_DONE:  out_valid_nxt = 1'b1;
         default:  in_ready_nxt  = 1'b0;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         round_q     <= '0;
         in_ready_q  <= 1'b1;
         load_init_q <= 1'b0;
         en_q        <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         round_q     <= round_nxt;
         in_ready_q  <= in_ready_nxt;
         load_init_q <= load_init_nxt;
         en_q        <= en_nxt;
         out_valid_q <= out_valid_nxt;
      end
   end

   des_key_sched u_key_sched (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .decrypt (bus.decrypt),
      .key     (bus.key),
      .step    (en_q),
      .round   (round_q),
      .subkey  (subkey)
   );

   assign bus.in_ready  = in_ready_q;
   assign bus.load_init = load_init_q;
   assign bus.en        = en_q;
   assign bus.round     = round_q;
   assign bus.subkey    = subkey;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed bench for des_round_ctrl using the FIPS 46-3 worked-example key.
module tb_des_round_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   des_round_ctrl_if bus ();

   des_round_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

   // K1..K16 for KEY_A
   logic [47:0] ks [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
   };

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
      check({tag, "_load_init"}, 64'(bus.load_init), 64'd0);
      check({tag, "_en"},        64'(bus.en),        64'd0);
      check({tag, "_round"},     64'(bus.round),     64'd0);
      check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
   endtask

   // One block from IDLE; disturb pokes inputs mid-flight, abort_at > 0 resets at that round
   task automatic run_block(input string tag, input bit dec, input bit disturb, input int abort_at);
      logic [47:0] exp_k;
      bus.key     = KEY_A;
      bus.decrypt = dec;
      bus.start   = 1'b1;
      step();
      bus.start   = 1'b0;
      bus.key     = 64'h0;
      check({tag, "_load_init"}, 64'(bus.load_init), 64'd1);
      check({tag, "_load_en"},   64'(bus.en),        64'd0);
      check({tag, "_load_rdy"},  64'(bus.in_ready),  64'd0);
      check({tag, "_load_ov"},   64'(bus.out_valid), 64'd0);
      for (int r = 1; r <= 16; r++) begin
         step();
         exp_k = dec ? ks[16 - r] : ks[r - 1];
         check($sformatf("%s_r%0d_en", tag, r),     64'(bus.en),        64'd1);
         check($sformatf("%s_r%0d_round", tag, r),  64'(bus.round),     64'(r));
         check($sformatf("%s_r%0d_subkey", tag, r), 64'(bus.subkey),    64'(exp_k));
         check($sformatf("%s_r%0d_li", tag, r),     64'(bus.load_init), 64'd0);
         check($sformatf("%s_r%0d_ov", tag, r),     64'(bus.out_valid), 64'd0);
         if (disturb && r == 5) begin
            bus.key     = ~KEY_A;
            bus.decrypt = ~dec;
            bus.start   = 1'b1;
         end
         if (disturb && r == 6)
            bus.start = 1'b0;
         if (r == abort_at) begin
            #2;
            rst = 1'b0;
            #1;
            check({tag, "_abort_en"},     64'(bus.en),        64'd0);
            check({tag, "_abort_round"},  64'(bus.round),     64'd0);
            check({tag, "_abort_li"},     64'(bus.load_init), 64'd0);
            check({tag, "_abort_ov"},     64'(bus.out_valid), 64'd0);
            check({tag, "_abort_subkey"}, 64'(bus.subkey),    64'd0);
            #3;
            rst = 1'b1;
            step();
            check_idle({tag, "_post_abort"});
            return;
         end
      end
      step();
      check({tag, "_done_ov"},    64'(bus.out_valid), 64'd1);
      check({tag, "_done_en"},    64'(bus.en),        64'd0);
      check({tag, "_done_round"}, 64'(bus.round),     64'd0);
      check({tag, "_done_rdy"},   64'(bus.in_ready),  64'd0);
   endtask

   initial begin
      int load_seen;
      int next_load;

      rst           = 1'b0;
      bus.start     = 1'b0;
      bus.decrypt   = 1'b0;
      bus.key       = 64'h0;
      bus.out_ready = 1'b0;

      // Reset state
      #13;
      check("rst_en",        64'(bus.en),        64'd0);
      check("rst_load_init", 64'(bus.load_init), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_round",     64'(bus.round),     64'd0);
      check("rst_subkey",    64'(bus.subkey),    64'd0);
      #10;
      rst = 1'b1;
      step();
      check_idle("post_rst");

      // Encrypt, then hold the result in DONE while start is pulsed
      run_block("enc", 1'b0, 1'b0, 0);
      bus.start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("hold%0d_ov", i),  64'(bus.out_valid), 64'd1);
         check($sformatf("hold%0d_en", i),  64'(bus.en),        64'd0);
         check($sformatf("hold%0d_rdy", i), 64'(bus.in_ready),  64'd0);
         check($sformatf("hold%0d_li", i),  64'(bus.load_init), 64'd0);
      end
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      step();
      check_idle("release");
      step();
      check_idle("no_queue");

      // Decrypt with inputs changed and start pulsed mid-flight; out_ready held high
      run_block("dec", 1'b1, 1'b1, 0);
      step();
      check_idle("dec_release");

      // Reset at round 7, then a clean encrypt must reproduce the reference
      bus.out_ready = 1'b0;
      run_block("abort", 1'b0, 1'b0, 7);
      step();
      check_idle("abort_quiet");
      run_block("enc2", 1'b0, 1'b0, 0);
      bus.out_ready = 1'b1;
      step();
      check_idle("enc2_release");

      // Back-to-back with start and out_ready tied high
      bus.key     = KEY_A;
      bus.decrypt = 1'b0;
      bus.start   = 1'b1;
      load_seen   = 0;
      next_load   = 0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         step();
         check($sformatf("b2b_c%0d_li_en", cyc), 64'(bus.load_init & bus.en), 64'd0);
         if (bus.load_init) begin
            check($sformatf("b2b_load%0d_cycle", load_seen), 64'(cyc), 64'(next_load));
            load_seen++;
            next_load = cyc + 19;
         end
      end
      check("b2b_load_count", 64'(load_seen), 64'd5);
      bus.start = 1'b0;
      for (int i = 0; i < 20; i++)
         step();
      check_idle("b2b_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
